// File: rtl/led_game_pkg.sv
// Shared types and constants for the LED reaction/memory game.
`timescale 1ns/1ps
package led_game_pkg;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    INIT  = 4'd1,
    CLEAR = 4'd2,
    GEN   = 4'd3,
    ARM   = 4'd4,
    PLAY  = 4'd5,
    SCORE = 4'd6,
    OVER  = 4'd7
  } state_e;

  // Active-low segments, bit0 = a .. bit6 = g
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // x^10 + x^7 + 1 taps as bit indices of the shift register
  localparam logic [9:0] LFSR_SEED  = 10'h001;
  localparam int         LFSR_TAP_A = 9;
  localparam int         LFSR_TAP_B = 6;

  localparam int         MAX_LEVEL_DEF = 9;
  localparam logic [9:0] LED_WIN       = 10'h3FF;

endpackage

// File: rtl/led_game_status_seg7.sv
// BCD digit to active-low 7-segment pattern; non-BCD codes blank the digit.
`timescale 1ns/1ps
module seg7_decoder
  import led_game_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/led_game_status.sv
// LED reaction/memory game controller: tick counter, LFSR pattern source,
// game FSM, BCD score and three 7-segment digit drivers.
`timescale 1ns/1ps
module led_game_status
  import led_game_pkg::*;
#(
  parameter int TICK_CYCLES = 16,
  parameter int MAX_LEVEL   = MAX_LEVEL_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [9:0] switch,
  output logic [9:0] led,
  output logic [6:0] point_msb,
  output logic [6:0] point_lsb,
  output logic [6:0] level_out,
  output logic       splitter
);

  localparam int            CW         = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] TICK_LAST  = CW'(TICK_CYCLES - 1);
  localparam logic [3:0]    LAST_LEVEL = 4'(MAX_LEVEL);

  state_e        _current;
  state_e        _next;
  logic [CW-1:0] count;
  logic          tick;
  logic [9:0]    lfsr;
  logic [9:0]    pattern;
  logic [3:0]    window;
  logic [3:0]    level;
  logic [7:0]    score;
  logic          won;
  logic          blink;
  logic          match;

  assign tick  = (count == TICK_LAST);
  assign match = (switch == pattern);

  // Two-digit BCD add that pins at 99 instead of wrapping.
  function automatic logic [7:0] bcd_add_sat(input logic [7:0] bcd, input logic [3:0] inc);
    logic [4:0] ones;
    logic [4:0] tens;
    ones = {1'b0, bcd[3:0]} + {1'b0, inc};
    tens = {1'b0, bcd[7:4]};
    if (ones > 5'd9) begin
      ones = ones - 5'd10;
      tens = tens + 5'd1;
    end
    if (tens > 5'd9) return 8'h99;
    return {tens[3:0], ones[3:0]};
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) _current <= IDLE;
    else        _current <= _next;
  end

  always_comb begin
    _next = _current;
    case (_current)
      IDLE:    if (!start) _next = INIT;
      INIT:    _next = GEN;
      CLEAR:   if (switch == 10'd0) _next = GEN;
      GEN:     _next = ARM;
      ARM:     _next = PLAY;
      // A match in the same cycle as the final tick still counts as a hit.
      PLAY:    if (match) _next = SCORE;
               else if (tick && window <= 4'd1) _next = OVER;
      SCORE:   _next = (level == LAST_LEVEL) ? OVER : CLEAR;
      OVER:    if (tick) _next = IDLE;
      default: _next = IDLE;
    endcase
  end

  always_comb begin
    led = 10'd0;
    case (_current)
      PLAY:    led = pattern;
      OVER:    led = won ? LED_WIN : 10'd0;
      default: led = 10'd0;
    endcase
    splitter = blink & (_current != IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
      lfsr  <= LFSR_SEED;
    end else begin
      count <= tick ? '0 : count + CW'(1);
      lfsr  <= {lfsr[8:0], lfsr[LFSR_TAP_A] ^ lfsr[LFSR_TAP_B]};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      level <= 4'd0;
      score <= 8'h00;
      won   <= 1'b0;
      blink <= 1'b0;
    end else begin
      if (_current == IDLE) blink <= 1'b0;
      else if (tick)        blink <= ~blink;
      case (_current)
        INIT: begin
          score <= 8'h00;
          level <= 4'd1;
          won   <= 1'b0;
        end
        SCORE: begin
          score <= bcd_add_sat(score, level);
          won   <= (level == LAST_LEVEL);
          if (level != LAST_LEVEL) level <= level + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Pattern and window are only consumed after GEN/ARM load them.
  always_ff @(posedge clock) begin
    if (_current == GEN) pattern <= lfsr;
    if (_current == ARM)
      window <= 4'd10 - level;
    else if (_current == PLAY && !match && tick)
      window <= window - 4'd1;
  end

  seg7_decoder u_seg_msb (.digit(score[7:4]), .seg(point_msb));
  seg7_decoder u_seg_lsb (.digit(score[3:0]), .seg(point_lsb));
  seg7_decoder u_seg_lvl (.digit(level),      .seg(level_out));

endmodule

// File: tb/tb_led_game_status.sv
// Randomized scoreboard bench for the LED game controller.
`timescale 1ns/1ps
module tb_led_game_status;

  localparam int TICK = 16;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [9:0] switch;
  logic [9:0] led;
  logic [6:0] point_msb;
  logic [6:0] point_lsb;
  logic [6:0] level_out;
  logic       splitter;

  led_game_status #(.TICK_CYCLES(TICK), .MAX_LEVEL(9)) dut (
    .clock(clock), .reset(reset), .start(start), .switch(switch),
    .led(led), .point_msb(point_msb), .point_lsb(point_lsb),
    .level_out(level_out), .splitter(splitter)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         st;
    int         score;
    int         level;
    logic [9:0] led;
  } exp_t;

  exp_t       exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         score_visits = 0;
  int         prev_st = 0;
  int         m_count;
  logic [9:0] m_lfsr;
  logic [9:0] gen_lfsr = 10'd0;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;
      2: return 7'b0100100;  3: return 7'b0110000;
      4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;
      8: return 7'b0000000;  9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [9:0] lfsr_next(input logic [9:0] x);
    return {x[8:0], x[9] ^ x[6]};
  endfunction

  function automatic int st_now();
    return int'(dut._current);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference tick counter and LFSR, stepped from the rules alone.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_count <= 0;
      m_lfsr  <= 10'h001;
    end else begin
      m_count <= (m_count == TICK - 1) ? 0 : m_count + 1;
      m_lfsr  <= lfsr_next(m_lfsr);
    end
  end

  // Monitor: state entries into CLEAR/OVER are the observable transactions.
  always @(negedge clock) begin
    int st;
    exp_t e;
    st = st_now();
    if (reset) begin
      if (st == 3) gen_lfsr = m_lfsr;
      if (st == 5 && prev_st != 5) check("pattern", {22'd0, led}, {22'd0, gen_lfsr});
      if (st == 6 && prev_st != 6) score_visits++;
      if ((st == 2 || st == 7) && st != prev_st) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_event: got state %0d, expected no event", st);
        end else begin
          e = exp_q.pop_front();
          check("ev_state", st, e.st);
          check("ev_msb",   {25'd0, point_msb}, {25'd0, seg_of(e.score / 10)});
          check("ev_lsb",   {25'd0, point_lsb}, {25'd0, seg_of(e.score % 10)});
          check("ev_level", {25'd0, level_out}, {25'd0, seg_of(e.level)});
          check("ev_led",   {22'd0, led},       {22'd0, e.led});
        end
      end
    end
    prev_st = st;
  end

  task automatic wait_state(input int s, input int budget, output bit ok, output int n);
    ok = 1'b0;
    for (n = 1; n <= budget; n++) begin
      @(negedge clock);
      if (st_now() == s) begin
        ok = 1'b1;
        return;
      end
    end
    n_cmp++;
    n_bad++;
    $display("FAIL wait_state: got state %0d, expected %0d within %0d cycles", st_now(), s, budget);
  endtask

  task automatic idle_check(input int score, input int level);
    check("idle_state", st_now(), 0);
    check("idle_led", {22'd0, led}, 32'd0);
    check("idle_splitter", {31'd0, splitter}, 32'd0);
    check("idle_msb", {25'd0, point_msb}, {25'd0, seg_of(score / 10)});
    check("idle_lsb", {25'd0, point_lsb}, {25'd0, seg_of(score % 10)});
    check("idle_level", {25'd0, level_out}, {25'd0, seg_of(level)});
  endtask

  // fail_lvl: level that times out (0 = none); abort_lvl: level where reset hits.
  task automatic play_game(input int fail_lvl, input bit wrong, input int abort_lvl);
    int score_ref;
    bit ok;
    int n;
    score_ref = 0;
    score_visits = 0;
    start = 1'b0;
    @(negedge clock);
    start = 1'b1;
    for (int lv = 1; lv <= 9; lv++) begin
      wait_state(5, 12, ok, n);
      if (!ok) return;
      if (lv == 1) check("start_latency", n + 1, 4);
      if (lv == abort_lvl) begin
        reset = 1'b0;
        #1;
        check("rst_state", st_now(), 0);
        check("rst_led", {22'd0, led}, 32'd0);
        check("rst_msb", {25'd0, point_msb}, {25'd0, seg_of(0)});
        check("rst_lsb", {25'd0, point_lsb}, {25'd0, seg_of(0)});
        check("rst_level", {25'd0, level_out}, {25'd0, seg_of(0)});
        @(negedge clock);
        reset = 1'b1;
        switch = 10'd0;
        @(negedge clock);
        return;
      end
      if (lv == fail_lvl) begin
        int w, plen, toggles;
        logic sp_prev;
        w = 10 - lv;
        exp_q.push_back('{7, score_ref, lv, 10'h000});
        switch = wrong ? (led ^ 10'h001) : 10'd0;
        plen = 1;
        toggles = 0;
        sp_prev = splitter;
        for (int k = 0; k < 200; k++) begin
          @(negedge clock);
          if (splitter != sp_prev) toggles++;
          sp_prev = splitter;
          if (st_now() == 5) plen++;
          else break;
        end
        n_cmp++;
        if (plen < (w - 1) * TICK + 1 || plen > w * TICK) begin
          n_bad++;
          $display("FAIL play_len L%0d: got %0d cycles, expected %0d..%0d", lv, plen, (w - 1) * TICK + 1, w * TICK);
        end
        check("timeout_to_over", st_now(), 7);
        check("blink_toggles", toggles, w);
        switch = 10'd0;
        wait_state(0, 3 * TICK, ok, n);
        if (ok) idle_check(score_ref, lv);
        return;
      end
      score_ref = (score_ref + lv > 99) ? 99 : score_ref + lv;
      if (lv == 9) exp_q.push_back('{7, score_ref, 9, 10'h3FF});
      else         exp_q.push_back('{2, score_ref, lv + 1, 10'h000});
      if (lv < 9) begin
        int d;
        logic [9:0] nz;
        d = $urandom_range(0, TICK - 1);
        for (int k = 0; k < d; k++) begin
          nz = 10'($urandom_range(1, 1023));
          switch = led ^ nz;
          @(negedge clock);
        end
      end
      switch = led;
      if (lv < 9) begin
        int h;
        wait_state(2, 4, ok, n);
        if (!ok) return;
        h = $urandom_range(0, 5);
        repeat (h) @(negedge clock);
        check("clear_hold", st_now(), 2);
        switch = 10'd0;
      end else begin
        wait_state(7, 4, ok, n);
        if (!ok) return;
        wait_state(0, 3 * TICK, ok, n);
        switch = 10'd0;
        if (ok) idle_check(score_ref, 9);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected end of run");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    int n;
    reset = 1'b0;
    start = 1'b1;
    switch = 10'd0;
    repeat (2) @(negedge clock);
    check("reset_state", st_now(), 0);
    check("reset_led", {22'd0, led}, 32'd0);
    check("reset_msb", {25'd0, point_msb}, {25'd0, 7'b1000000});
    check("reset_lsb", {25'd0, point_lsb}, {25'd0, 7'b1000000});
    check("reset_level", {25'd0, level_out}, {25'd0, 7'b1000000});
    check("reset_splitter", {31'd0, splitter}, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 128; i++) begin
      @(negedge clock);
      check("hold_state", st_now(), 0);
      check("hold_led", {22'd0, led}, 32'd0);
      check("hold_count", {28'd0, dut.count}, m_count);
    end

    play_game(0, 1'b0, 0);
    check("score_visits", score_visits, 9);

    play_game(1, 1'b0, 0);
    play_game(2, 1'b1, 0);
    play_game(0, 1'b0, 3);
    check("post_reset_level", {25'd0, level_out}, {25'd0, seg_of(0)});
    play_game(1, 1'b0, 0);

    exp_q.push_back('{7, 0, 1, 10'h000});
    start = 1'b0;
    wait_state(7, 12 * TICK, ok, n);
    wait_state(0, 3 * TICK, ok, n);
    @(negedge clock);
    check("restart_held", st_now(), 1);
    exp_q.push_back('{7, 0, 1, 10'h000});
    start = 1'b1;
    wait_state(7, 12 * TICK, ok, n);
    wait_state(0, 3 * TICK, ok, n);

    for (int g = 0; g < 4; g++)
      play_game($urandom_range(0, 9), 1'($urandom_range(0, 1)), 0);

    repeat (3) @(negedge clock);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led_game_status.md
Name: led_game_status

Overview:
- Top-level controller of the LED reaction/memory game.
- Shows a pseudo-random 10-bit pattern on `led`; the player copies it on `switch` within a shrinking time window.
- Each success adds the level number to a 2-digit BCD score and advances the level (1..9).
- Drives three 7-segment digits (score tens, score ones, level) and a tick-blink indicator.

Parameters:
- TICK_CYCLES, 16, clock cycles per game tick (FPGA build overrides with 50_000_000).
- MAX_LEVEL, 9, last level; clearing it ends the game.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  active-low start button, level-sensitive.
- switch  in  10  player input pattern.
- led  out  10  displayed pattern.
- point_msb  out  7  7-seg, score tens digit.
- point_lsb  out  7  7-seg, score ones digit.
- level_out  out  7  7-seg, current level digit.
- splitter  out  1  tick blink indicator.

Behaviour:
- Reset (reset=0, async):
  - _current=IDLE, count=0, level=0, score=00, led=0, splitter=0.
  - LFSR=10'h001.
- count: free-running 0..TICK_CYCLES-1, wraps. tick=1 for one cycle when count==TICK_CYCLES-1.
- LFSR: 10-bit Fibonacci, taps x^10+x^7+1, advances every clock, never zero.
- 7-seg encoding: active-low, bit0=a..bit6=g.
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - level_out shows level; point_msb/point_lsb show BCD score digits.
- splitter: toggles on every tick while _current!=IDLE; forced 0 in IDLE.
- State register _current is 4 bits. Encodings are fixed:
  - 0 IDLE: led=0. start==0 -> INIT. Otherwise stay.
  - 1 INIT: score=00, level=1 -> GEN.
  - 2 CLEAR: led=0. switch==0 -> GEN.
  - 3 GEN: pattern<=LFSR -> ARM.
  - 4 ARM: window<=10-level (ticks) -> PLAY.
  - 5 PLAY: led=pattern. Every cycle:
    - if switch==pattern -> SCORE;
    - else on tick decrement window; window reaching 0 -> OVER.
    - Match has priority over timeout in the same cycle.
  - 6 SCORE: score+=level (BCD add, saturate 99).
    - level==MAX_LEVEL -> OVER.
    - Otherwise level+=1 -> CLEAR.
  - 7 OVER: led=10'h3FF on win (level==MAX_LEVEL and last play matched), else 10'h000.
    - Hold one tick, then -> IDLE. Score and level remain displayed in IDLE.
  - Codes 8-15: -> IDLE.
- Latency: start low in IDLE to first led pattern = 4 clocks (INIT, GEN, ARM, PLAY).
- switch is ignored outside PLAY and CLEAR.
- Holding start low when returning to IDLE immediately restarts the game on the next clock.
- reset low mid-game: immediate IDLE with all reset values.

Decomposition:
- Package led_game_pkg:
  - state enum (IDLE..OVER with the fixed codes above);
  - 7-seg digit constants;
  - LFSR seed/taps;
  - MAX_LEVEL default.
- One sub-module, seg7_decoder (4-bit BCD in, 7-bit active-low out), instantiated three times.
- FSM, counter, LFSR and BCD score stay in led_game_status.

Test Plan:
- Reset: assert reset=0 -> led=0, point_msb=point_lsb=1000000, level_out=1000000, splitter=0, _current=0.
- Idle hold: reset=1, start=1 for 128 clocks -> _current stays 0, led=0, count cycles 0..15.
- Perfect game (start=0 pulse; set switch=led whenever _current==5 and switch=0 whenever _current==2):
  - 9 SCORE visits;
  - final score 45 -> point_msb=0011001, point_lsb=0010010, level_out=0010000;
  - OVER shows led=3FF, then _current=0.
- Timeout: start game, keep switch=0 -> PLAY at level 1 lasts 9 ticks (144 clocks ±1 tick) -> OVER led=0 -> IDLE, score 00, level_out=1111001.
- Wrong/late input:
  - switch=pattern^1 in PLAY -> no SCORE, times out.
  - switch held nonzero in CLEAR -> stays in state 2 until switch=0.
- Reset mid-PLAY at level 3: reset=0 for one clock -> _current=0, score 00, level 0, led 0. Next start=0 begins again at level 1.
